// File: rtl/index_sequencer_if.sv
// Control/status bundle between a sweep controller and the index sequencer.
interface index_sequencer_if;
    logic       start;
    logic       stop;
    logic [1:0] mode;
    logic       oneshot;
    logic [2:0] idx;
    logic       busy;
    logic       step;
    logic       wrap;
    logic       done;

    modport master (
        output start, stop, mode, oneshot,
        input  idx, busy, step, wrap, done
    );

    modport slave (
        input  start, stop, mode, oneshot,
        output idx, busy, step, wrap, done
    );
endinterface

// File: rtl/index_sequencer.sv
// Timed 3-bit index generator (up / down / ping-pong / hold) feeding a 3-to-8
// one-hot decoder. A prescaler sets the step rate; start/stop select free-run
// or single-sweep operation; step/wrap/done are registered status pulses that
// line up with the cycle the new index appears.
module index_sequencer #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    index_sequencer_if.slave  bus
);
    localparam int unsigned    PW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0]  PRE_MAX  = PW'(CLK_DIV - 1);

    localparam logic [1:0] MODE_UP   = 2'b00;
    localparam logic [1:0] MODE_DOWN = 2'b01;
    localparam logic [1:0] MODE_PP   = 2'b10;

    typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_e;

    state_e        state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic          dir_q, dir_d;        // 0 = up, 1 = down (ping-pong only)
    logic [PW-1:0] pre_q, pre_d;
    logic [1:0]    mode_q, mode_d;
    logic          oneshot_q, oneshot_d;
    logic          busy_q, busy_d;
    logic          step_q, step_d;
    logic          wrap_q, wrap_d;
    logic          done_q, done_d;

    logic [2:0]    nxt_idx;
    logic          nxt_dir;
    logic          nxt_wrap;
    logic          term;

    // Candidate next index for a step in the latched mode, plus wrap and
    // single-sweep terminal detection for that step.
    always_comb begin
        nxt_idx  = idx_q;
        nxt_dir  = dir_q;
        nxt_wrap = 1'b0;
        term     = 1'b0;
        case (mode_q)
            MODE_UP: begin
                nxt_idx  = idx_q + 3'd1;
                nxt_wrap = (nxt_idx == 3'd0);
                term     = (nxt_idx == 3'd7);
            end
            MODE_DOWN: begin
                nxt_idx  = idx_q - 3'd1;
                nxt_wrap = (nxt_idx == 3'd7);
                term     = (nxt_idx == 3'd0);
            end
            MODE_PP: begin
                if (!dir_q) begin
                    nxt_idx = idx_q + 3'd1;
                    if (nxt_idx == 3'd7) nxt_dir = 1'b1;
                end else begin
                    nxt_idx = idx_q - 3'd1;
                    if (nxt_idx == 3'd0) nxt_dir = 1'b0;
                end
                nxt_wrap = (nxt_idx == 3'd7) || (nxt_idx == 3'd0);
                // A ping-pong sweep always launches at 0 going up, so the
                // first return to 0 closes the sweep.
                term     = (nxt_idx == 3'd0);
            end
            default: begin
                term = 1'b1;   // hold: the first step ends a single sweep
            end
        endcase
    end

    // Next-state logic: launch from IDLE, prescaled stepping and stop in RUN.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        dir_d     = dir_q;
        pre_d     = pre_q;
        mode_d    = mode_q;
        oneshot_d = oneshot_q;
        busy_d    = busy_q;
        step_d    = 1'b0;
        wrap_d    = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.stop) begin
                    state_d   = RUN;
                    busy_d    = 1'b1;
                    mode_d    = bus.mode;
                    oneshot_d = bus.oneshot;
                    pre_d     = '0;
                    dir_d     = 1'b0;
                    if (bus.mode == MODE_DOWN)   idx_d = 3'd7;
                    else if (bus.mode != 2'b11)  idx_d = 3'd0;
                end
            end
            default: begin
                if (bus.stop) begin
                    // Stop beats any step due this cycle; idx/dir freeze.
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    pre_d   = '0;
                end else if (pre_q == PRE_MAX) begin
                    pre_d  = '0;
                    idx_d  = nxt_idx;
                    dir_d  = nxt_dir;
                    step_d = 1'b1;
                    wrap_d = nxt_wrap;
                    if (oneshot_q && term) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    pre_d = pre_q + 1'b1;
                end
            end
        endcase
    end

    // Single register bank for FSM state and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= 3'd0;
            dir_q     <= 1'b0;
            pre_q     <= '0;
            mode_q    <= 2'b00;
            oneshot_q <= 1'b0;
            busy_q    <= 1'b0;
            step_q    <= 1'b0;
            wrap_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            dir_q     <= dir_d;
            pre_q     <= pre_d;
            mode_q    <= mode_d;
            oneshot_q <= oneshot_d;
            busy_q    <= busy_d;
            step_q    <= step_d;
            wrap_q    <= wrap_d;
            done_q    <= done_d;
        end
    end

    assign bus.idx  = idx_q;
    assign bus.busy = busy_q;
    assign bus.step = step_q;
    assign bus.wrap = wrap_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_index_sequencer.sv
// Directed bench for index_sequencer: four instances (CLK_DIV 4/1/2/3) share
// the same stimulus; each scenario resets all and observes one instance.
module tb_index_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, stop = 1'b0, oneshot = 1'b0;
    logic [1:0] mode = 2'b00;
    int         sel = 0;
    int         n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    index_sequencer_if bus_a ();
    index_sequencer_if bus_b ();
    index_sequencer_if bus_c ();
    index_sequencer_if bus_d ();

    assign bus_a.start = start; assign bus_a.stop = stop; assign bus_a.mode = mode; assign bus_a.oneshot = oneshot;
    assign bus_b.start = start; assign bus_b.stop = stop; assign bus_b.mode = mode; assign bus_b.oneshot = oneshot;
    assign bus_c.start = start; assign bus_c.stop = stop; assign bus_c.mode = mode; assign bus_c.oneshot = oneshot;
    assign bus_d.start = start; assign bus_d.stop = stop; assign bus_d.mode = mode; assign bus_d.oneshot = oneshot;

    index_sequencer #(.CLK_DIV(4)) u_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    index_sequencer #(.CLK_DIV(1)) u_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
    index_sequencer #(.CLK_DIV(2)) u_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));
    index_sequencer #(.CLK_DIV(3)) u_d (.clk(clk), .rst_n(rst_n), .bus(bus_d));

    logic [2:0] o_idx;
    logic       o_busy, o_step, o_wrap, o_done;

    // Route the observed instance's outputs to one set of probe signals.
    always_comb begin
        case (sel)
            1:       {o_idx, o_busy, o_step, o_wrap, o_done} = {bus_b.idx, bus_b.busy, bus_b.step, bus_b.wrap, bus_b.done};
            2:       {o_idx, o_busy, o_step, o_wrap, o_done} = {bus_c.idx, bus_c.busy, bus_c.step, bus_c.wrap, bus_c.done};
            3:       {o_idx, o_busy, o_step, o_wrap, o_done} = {bus_d.idx, bus_d.busy, bus_d.step, bus_d.wrap, bus_d.done};
            default: {o_idx, o_busy, o_step, o_wrap, o_done} = {bus_a.idx, bus_a.busy, bus_a.step, bus_a.wrap, bus_a.done};
        endcase
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input int idx, input int busy,
                           input int step, input int wrap, input int done);
        chk({tag, ".idx"},  int'(o_idx),  idx);
        chk({tag, ".busy"}, int'(o_busy), busy);
        chk({tag, ".step"}, int'(o_step), step);
        chk({tag, ".wrap"}, int'(o_wrap), wrap);
        chk({tag, ".done"}, int'(o_done), done);
    endtask

    // Hold reset for two cycles; release on a falling edge.
    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; stop = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // ---- up free-run, CLK_DIV=4, with mode change + start during RUN ----
        sel = 0;
        do_reset();
        chk_all("rst", 0, 0, 0, 0, 0);
        mode = 2'b00; oneshot = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk_all("up_launch", 0, 1, 0, 0, 0);
        for (int k = 1; k <= 9; k++) begin
            if (k == 3) begin mode = 2'b01; start = 1'b1; end
            repeat (3) begin
                @(negedge clk);
                chk_all("up_wait", (k - 1) % 8, 1, 0, 0, 0);
            end
            @(negedge clk);
            chk_all("up_step", k % 8, 1, 1, (k % 8 == 0) ? 1 : 0, 0);
        end
        start = 1'b0;
        stop = 1'b1;
        @(negedge clk); stop = 1'b0;
        chk_all("up_stop", 1, 0, 0, 0, 0);

        // ---- hold oneshot, CLK_DIV=4, idx carried over from the stop ----
        mode = 2'b11; oneshot = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk_all("hold_launch", 1, 1, 0, 0, 0);
        repeat (3) begin
            @(negedge clk);
            chk_all("hold_wait", 1, 1, 0, 0, 0);
        end
        @(negedge clk);
        chk_all("hold_done", 1, 0, 1, 0, 1);
        @(negedge clk);
        chk_all("hold_after", 1, 0, 0, 0, 0);

        // ---- asynchronous reset mid-cycle at idx=6 ----
        do_reset();
        mode = 2'b00; oneshot = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (24) @(negedge clk);
        chk_all("pre_rst", 6, 1, 1, 0, 0);
        #2 rst_n = 1'b0;
        #1 chk_all("async_rst", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk_all("rst_relaunch", 0, 1, 0, 0, 0);
        repeat (3) @(negedge clk);
        @(negedge clk);
        chk_all("rst_first_step", 1, 1, 1, 0, 0);

        // ---- ping-pong oneshot, CLK_DIV=1 ----
        sel = 1;
        do_reset();
        mode = 2'b10; oneshot = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk_all("pp_launch", 0, 1, 0, 0, 0);
        for (int k = 1; k <= 14; k++) begin
            int e;
            e = (k <= 7) ? k : 14 - k;
            @(negedge clk);
            chk_all("pp_step", e, (k < 14) ? 1 : 0, 1, (e == 7 || e == 0) ? 1 : 0, (k == 14) ? 1 : 0);
        end
        @(negedge clk);
        chk_all("pp_after", 0, 0, 0, 0, 0);

        // ---- down free-run, CLK_DIV=2, stop on a due step at idx=5 ----
        sel = 2;
        do_reset();
        mode = 2'b01; oneshot = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk_all("dn_launch", 7, 1, 0, 0, 0);
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            chk_all("dn_wait", 8 - k, 1, 0, 0, 0);
            @(negedge clk);
            chk_all("dn_step", 7 - k, 1, 1, 0, 0);
        end
        @(negedge clk);
        chk_all("dn_wait5", 5, 1, 0, 0, 0);
        stop = 1'b1;
        @(negedge clk); stop = 1'b0;
        chk_all("dn_stop", 5, 0, 0, 0, 0);
        @(negedge clk);
        chk_all("dn_idle", 5, 0, 0, 0, 0);
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        chk_all("dn_both", 5, 0, 0, 0, 0);
        stop = 1'b0;
        @(negedge clk); start = 1'b0;
        chk_all("dn_reload", 7, 1, 0, 0, 0);

        // ---- up oneshot, CLK_DIV=3, then immediate restart ----
        sel = 3;
        do_reset();
        mode = 2'b00; oneshot = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk_all("os_launch", 0, 1, 0, 0, 0);
        for (int k = 1; k <= 7; k++) begin
            repeat (2) begin
                @(negedge clk);
                chk_all("os_wait", k - 1, 1, 0, 0, 0);
            end
            @(negedge clk);
            chk_all("os_step", k, (k < 7) ? 1 : 0, 1, 0, (k == 7) ? 1 : 0);
        end
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk_all("os_restart", 0, 1, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk_all("os_restart_step", 1, 1, 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/index_sequencer.md
# index_sequencer

Timed 3-bit index generator that sits directly upstream of the 3-to-8 one-hot decoder and drives its `in` input, producing running-light, reverse and ping-pong patterns. A prescaler sets the step rate. A start/stop interface controls free-running or single-sweep operation. Status pulses let a controller chain sweeps.

## Interface
- `CLK_DIV`, default 4: clock cycles per index step; legal range 1..65535; the prescaler counter is `$clog2(CLK_DIV)` bits wide, minimum 1.
- `clk`  input  1  clock; all state changes on its rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `start`  input  1  level-sampled each cycle; a high sample while IDLE launches a run.
- `stop`  input  1  a high sample while RUN ends the run.
- `mode`  input  2  00 up, 01 down, 10 ping-pong, 11 hold; latched when a run launches.
- `oneshot`  input  1  latched when a run launches; 1 selects a single sweep.
- `idx`  output  3  index to the decoder; registered.
- `busy`  output  1  high while in RUN.
- `step`  output  1  one-cycle pulse in the first cycle `idx` shows a stepped value.
- `wrap`  output  1  one-cycle pulse on an end-of-range event.
- `done`  output  1  one-cycle pulse when a oneshot sweep completes.

## Operation
- States: IDLE and RUN.
- Reset values: IDLE, `idx`=0, `busy`=`step`=`wrap`=`done`=0, prescaler=0, direction=up.
- IDLE with `start`=1 and `stop`=0:
  - go to RUN and latch `mode` and `oneshot`;
  - clear the prescaler;
  - load `idx`: 0 for up and ping-pong, 7 for down, unchanged for hold;
  - set direction to up;
  - no `step` pulse on load.
- `start` while in RUN has no effect.
- `stop`=1 in RUN: go to IDLE at the next edge and freeze `idx`; a step due in that same cycle is suppressed.
- `start` and `stop` both high: `stop` wins, so IDLE stays IDLE.
- Prescaler in RUN:
  - counts 0..CLK_DIV-1;
  - a step fires on the edge where the count equals CLK_DIV-1, and the count returns to 0;
  - with CLK_DIV=1, a step fires on every RUN cycle.
- Step by mode:
  - up: `idx`+1 modulo 8; `wrap` when the new value is 0 (7→0).
  - down: `idx`-1 modulo 8; `wrap` when the new value is 7 (0→7).
  - ping-pong: move one position in the current direction; `wrap` when the new value is 7 or 0.
  - ping-pong direction flips to down on reaching 7 and to up on reaching 0, so the sequence is 0,1..7,6..0,1…; no value repeats at the ends.
  - hold: `idx` unchanged; `step` still pulses; `wrap` never fires.
- Oneshot termination: on the step that produces the terminal value, also pulse `done`, go to IDLE and drop `busy` in the same cycle. Terminal step by mode:
  - up: `idx` becomes 7 (7 steps);
  - down: `idx` becomes 0 (7 steps);
  - ping-pong: `idx` returns to 0 (14 steps);
  - hold: the first step.
  - `idx` holds the terminal value afterwards.
  - In oneshot mode, up/down never wrap; ping-pong pulses `wrap` at 7 and, together with `done`, at the final 0.
- A `mode` or `oneshot` change during RUN is ignored until the next launch.

## Timing
- Launch: `start` sampled high at edge E gives `busy`=1 and the loaded `idx` after E.
- First step lands at edge E+CLK_DIV; subsequent steps every CLK_DIV cycles.
- `step`, `wrap` and `done` are registered and coincide exactly with the cycle the new `idx` appears.
- The cycle after `done`, `busy`=0. A `start` sampled in that cycle relaunches, giving a one-cycle idle gap at minimum.
- Stop: `stop` sampled at edge S gives `busy`=0 after S; `idx` and direction hold; the prescaler clears.
- Reset mid-run: all outputs return to reset values immediately, without waiting for a clock edge. The first launch can occur on the first edge after `rst_n` rises.
- No combinational path from inputs to outputs.

## Test plan
- Up free-run, CLK_DIV=4, start pulse → `idx` 0 for 4 cycles, then 1,2…7,0; `step` every 4 cycles; `wrap` only on the 7→0 step (8th step); `busy` stays 1.
- Ping-pong oneshot, CLK_DIV=1 → `idx` 0,1..7,6..0 over 14 cycles; `wrap` at 7 and at the final 0; `done`=1 with the final 0; `busy`=0 next cycle.
- Down free-run, CLK_DIV=2; assert `stop` on the cycle a step is due while `idx`=5 → `idx` stays 5 and no `step` pulse; `start`+`stop` together then stays IDLE; a later `start` alone reloads 7.
- Change `mode` from up to down mid-run and raise `start` during RUN → pattern unchanged, no relaunch; hold-mode oneshot → `idx` constant, single `step`+`done` after CLK_DIV cycles.
- Drop `rst_n` asynchronously, mid-cycle, while `idx`=6 → `idx`=0 and `busy`=0 before the next edge; `start` on the first edge after release launches normally.
- Up oneshot, CLK_DIV=3 → `done` at `idx`=7 after 21 cycles, no `wrap`; restart the cycle after `done` → `idx` reloads to 0.
